// File: rtl/prog_loader.sv
// Byte-stream loader: frames I/D words into the BRAM write ports, then releases the core.
// Optional PROG_LOADER_CHECKSUM_EN adds a trailing 8-bit zero-sum CSUM byte per frame.
module prog_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic                  d_bram_init_done,
    output logic                  cpu_stall,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_CMD,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_RUN,
        S_ERR
    } state_t;

    state_t          state;
    logic            tgt_d;
    logic [1:0]      byte_cnt;
    logic [15:0]     word_idx;
    logic [15:0]     len;
    logic [23:0]     wbuf;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]      sum;
`endif

    logic                  xfer;
    logic [15:0]           len_n;
    logic [DATA_WIDTH-1:0] word_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic                  last_word;

    assign xfer      = in_valid & in_ready;
    assign len_n     = {in_byte, len[7:0]};
    // Bytes arrive LSB first, so each new byte enters at the top.
    assign word_n    = {in_byte, wbuf};
    assign addr_n    = {word_idx[ADDR_WIDTH-3:0], 2'b00};
    assign last_word = (word_idx == len - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_CMD;
            in_ready         <= 1'b0;
            i_w_addr         <= '0;
            i_w_dat          <= '0;
            i_w_enb          <= 1'b0;
            d_w_addr         <= '0;
            d_w_dat          <= '0;
            d_w_enb          <= 1'b0;
            d_bram_init_done <= 1'b0;
            cpu_stall        <= 1'b1;
            error            <= 1'b0;
            tgt_d            <= 1'b0;
            byte_cnt         <= '0;
            word_idx         <= '0;
            len              <= '0;
            wbuf             <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum              <= '0;
`endif
        end else begin
            in_ready <= 1'b1;
            i_w_enb  <= 1'b0;
            d_w_enb  <= 1'b0;
            case (state)
                S_CMD: if (xfer) begin
                    case (in_byte)
                        8'h49: begin
                            tgt_d <= 1'b0;
                            state <= S_LEN_LO;
                        end
                        8'h44: begin
                            tgt_d <= 1'b1;
                            state <= S_LEN_LO;
                        end
                        8'h47: begin
                            cpu_stall        <= 1'b0;
                            d_bram_init_done <= 1'b1;
                            state            <= S_RUN;
                        end
                        default: begin
                            error <= 1'b1;
                            state <= S_ERR;
                        end
                    endcase
                end
                S_LEN_LO: if (xfer) begin
                    len[7:0] <= in_byte;
                    state    <= S_LEN_HI;
                end
                S_LEN_HI: if (xfer) begin
                    len <= len_n;
                    if (len_n == 16'd0) begin
                        state <= S_CMD;
                    end else if (len_n > 16'(MAX_WORDS)) begin
                        error <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        word_idx <= '0;
                        byte_cnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum      <= '0;
`endif
                        state    <= S_DATA;
                    end
                end
                S_DATA: if (xfer) begin
                    wbuf     <= word_n[31:8];
                    byte_cnt <= byte_cnt + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum      <= sum + in_byte;
`endif
                    if (byte_cnt == 2'd3) begin
                        if (tgt_d) begin
                            d_w_addr <= addr_n;
                            d_w_dat  <= word_n;
                            d_w_enb  <= 1'b1;
                        end else begin
                            i_w_addr <= addr_n;
                            i_w_dat  <= word_n;
                            i_w_enb  <= 1'b1;
                        end
                        word_idx <= word_idx + 16'd1;
                        if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state <= S_CMD;
`endif
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CSUM: if (xfer) begin
                    if (8'(sum + in_byte) == 8'h00) begin
                        state <= S_CMD;
                    end else begin
                        error <= 1'b1;
                        state <= S_ERR;
                    end
                end
`endif
                S_RUN: if (xfer && in_byte == 8'h52) begin
                    cpu_stall        <= 1'b1;
                    d_bram_init_done <= 1'b0;
                    state            <= S_CMD;
                end
                S_ERR: begin
                    error            <= 1'b1;
                    cpu_stall        <= 1'b1;
                    d_bram_init_done <= 1'b0;
                end
                default: begin
                    error <= 1'b1;
                    state <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected BRAM writes queued at drive time,
// popped and compared as write pulses appear on either port.
module tb_prog_loader;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_byte = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] i_w_addr;
    logic [DW-1:0] i_w_dat;
    logic          i_w_enb;
    logic [AW-1:0] d_w_addr;
    logic [DW-1:0] d_w_dat;
    logic          d_w_enb;
    logic          d_bram_init_done;
    logic          cpu_stall;
    logic          error;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic          tgt_d;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] payload[$];

    prog_loader dut (
        .clk(clk), .rst(rst),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
        .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
        .d_bram_init_done(d_bram_init_done),
        .cpu_stall(cpu_stall), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (i_w_enb || d_w_enb)) begin
            check("wr_both", 64'(i_w_enb & d_w_enb), 64'd0);
            if (sb.size() == 0) begin
                check("wr_unexp", 64'd1, 64'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_tgt", 64'(d_w_enb), 64'(e.tgt_d));
                if (d_w_enb) begin
                    check("wr_addr", 64'(d_w_addr), 64'(e.addr));
                    check("wr_dat", 64'(d_w_dat), 64'(e.dat));
                end else begin
                    check("wr_addr", 64'(i_w_addr), 64'(e.addr));
                    check("wr_dat", 64'(i_w_dat), 64'(e.dat));
                end
            end
        end
    end

    // Presents one byte and returns just after the edge that accepted it.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("rdy_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cyc);
        in_valid = 1'b0;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    // Sends a full I/D frame from `payload`, queueing each expected write.
    task automatic frame(input logic [7:0] cmd);
        logic [7:0] cs;
        int n;
        n  = payload.size();
        cs = 8'h00;
        send(cmd);
        send(n[7:0]);
        send(n[15:8]);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.tgt_d = (cmd == 8'h44);
            e.addr  = AW'(i * 4);
            e.dat   = payload[i];
            sb.push_back(e);
            for (int k = 0; k < 4; k++) begin
                logic [31:0] w;
                w  = payload[i];
                cs = cs + w[8*k +: 8];
                send(w[8*k +: 8]);
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (n > 0) send(8'(-cs));
`endif
        payload.delete();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_stall", 64'(cpu_stall), 64'd1);
        check("rst_done", 64'(d_bram_init_done), 64'd0);
        check("rst_err", 64'(error), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready1", 64'(in_ready), 64'd1);
    endtask

    initial begin
        do_reset();

        // data load, two words
        payload.push_back(32'h0000_0001);
        payload.push_back(32'h0000_0002);
        frame(8'h44);
        idle(3);
        check("dl_stall", 64'(cpu_stall), 64'd1);
        check("dl_sb", 64'(sb.size()), 64'd0);

        // instruction load then GO
        payload.push_back(32'h0053_02B3);
        frame(8'h49);
        idle(3);
        check("go_stall0", 64'(cpu_stall), 64'd1);
        check("go_done0", 64'(d_bram_init_done), 64'd0);
        send(8'h47);
        check("go_stall1", 64'(cpu_stall), 64'd0);
        check("go_done1", 64'(d_bram_init_done), 64'd1);
        send(8'h44);
        check("run_ign", 64'(cpu_stall), 64'd0);

        // reload path
        send(8'h52);
        check("rl_stall", 64'(cpu_stall), 64'd1);
        check("rl_done", 64'(d_bram_init_done), 64'd0);
        send(8'h44); send(8'h00); send(8'h00);
        send(8'h47);
        check("rl_go", 64'(cpu_stall), 64'd0);
        send(8'h52);
        idle(2);

        // back-to-back frames, in_valid never dropped
        payload.push_back(32'hDDCC_BBAA);
        frame(8'h44);
        payload.push_back(32'h4433_2211);
        frame(8'h44);
        idle(3);
        check("b2b_sb", 64'(sb.size()), 64'd0);

        // maximum frame length
        for (int i = 0; i < 256; i++) payload.push_back($urandom);
        frame(8'h49);
        idle(3);
        check("max_sb", 64'(sb.size()), 64'd0);
        check("max_err", 64'(error), 64'd0);

        // bad command
        send(8'h5A);
        check("bad_err", 64'(error), 64'd1);
        send(8'h47);
        idle(2);
        check("bad_stall", 64'(cpu_stall), 64'd1);
        check("bad_done", 64'(d_bram_init_done), 64'd0);
        check("bad_sticky", 64'(error), 64'd1);
        do_reset();

        // oversize length
        send(8'h49); send(8'h01); send(8'h01);
        check("len_err", 64'(error), 64'd1);
        do_reset();

        // reset mid-word: partial word dropped
        payload.push_back(32'h1234_5678);
        frame(8'h49);
        idle(2);
        send(8'h44); send(8'h01); send(8'h00);
        send(8'hAA); send(8'hBB);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("ar_ready", 64'(in_ready), 64'd0);
        check("ar_iaddr", 64'(i_w_addr), 64'd0);
        check("ar_idat", 64'(i_w_dat), 64'd0);
        check("ar_denb", 64'(d_w_enb), 64'd0);
        check("ar_stall", 64'(cpu_stall), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);
        check("ar_sb", 64'(sb.size()), 64'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        payload.push_back(32'h0403_0201);
        frame(8'h44);
        idle(2);
        check("cs_ok", 64'(error), 64'd0);
        send(8'h44); send(8'h01); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        sb.push_back(wr_t'{1'b1, AW'(0), 32'h0403_0201});
        send(8'hF5);
        idle(2);
        check("cs_bad", 64'(error), 64'd1);
        send(8'h47);
        idle(2);
        check("cs_nogo", 64'(cpu_stall), 64'd1);
        do_reset();
`endif

        idle(4);
        check("final_sb", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
